// File: rtl/ex_stage_if.sv
// Decode-to-execute bus: the operation and operands that decode hands to the
// execute stage each cycle.
//   master : decode side, drives every signal
//   slave  : execute side, samples every signal
// Signals: aluop, alusel, reg1, reg2 (DATA_W), wd (5), wreg.
`ifndef EX_STAGE_DEFS
`define EX_STAGE_DEFS
`define RstEnable          1'b0
`define AluOpBus           7:0
`define AluSelBus          2:0
`define EXE_NOP_OP         8'b0000_0000
`define EXE_AND_OP         8'b0010_0100
`define EXE_OR_OP          8'b0010_0101
`define EXE_XOR_OP         8'b0010_0110
`define EXE_SLL_OP         8'b0111_1100
`define EXE_SRL_OP         8'b0000_0010
`define EXE_SRA_OP         8'b0000_0011
`define EXE_ADD_OP         8'b0010_0000
`define EXE_SUB_OP         8'b0010_0010
`define EXE_SLT_OP         8'b0010_1010
`define EXE_SLTU_OP        8'b0010_1011
`define EXE_RES_NOP        3'b000
`define EXE_RES_LOGIC      3'b001
`define EXE_RES_SHIFT      3'b010
`define EXE_RES_ARITHMETIC 3'b100
`endif

interface ex_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic [`AluOpBus]  aluop;
  logic [`AluSelBus] alusel;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] reg2;
  logic [4:0]        wd;
  logic              wreg;

  modport master (output aluop, alusel, reg1, reg2, wd, wreg);
  modport slave  (input  aluop, alusel, reg1, reg2, wd, wreg);
endinterface

// File: rtl/ex_stage.sv
// Execute stage of the RV32I pipeline. Registers the decode outputs in an
// ID/EX latch and produces the ALU result combinationally from it; wdata_o,
// wd_o and wreg_o feed both the MEM latch and decode's forwarding inputs.
// Ports:
//   clk, rst    : clock, synchronous active-low reset
//   id          : decode bus (ex_stage_if.slave)
//   id_stall_i  : decode held this cycle -> bubble loaded
//   ex_stall_i  : this stage held -> latch keeps its contents
//   wdata_o, wd_o, wreg_o : result, destination, write enable
//   stallreq_o  : hold request while a serial shift runs
// Build option: define SERIAL_SHIFT_EN for a 1-bit/cycle shifter driven by a
// small FSM; otherwise shifts use a single-cycle barrel shifter.
`ifndef EX_STAGE_DEFS
`define EX_STAGE_DEFS
`define RstEnable          1'b0
`define AluOpBus           7:0
`define AluSelBus          2:0
`define EXE_NOP_OP         8'b0000_0000
`define EXE_AND_OP         8'b0010_0100
`define EXE_OR_OP          8'b0010_0101
`define EXE_XOR_OP         8'b0010_0110
`define EXE_SLL_OP         8'b0111_1100
`define EXE_SRL_OP         8'b0000_0010
`define EXE_SRA_OP         8'b0000_0011
`define EXE_ADD_OP         8'b0010_0000
`define EXE_SUB_OP         8'b0010_0010
`define EXE_SLT_OP         8'b0010_1010
`define EXE_SLTU_OP        8'b0010_1011
`define EXE_RES_NOP        3'b000
`define EXE_RES_LOGIC      3'b001
`define EXE_RES_SHIFT      3'b010
`define EXE_RES_ARITHMETIC 3'b100
`endif

module ex_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  ex_stage_if.slave         id,
  input  logic              id_stall_i,
  input  logic              ex_stall_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic              stallreq_o
);

  logic [`AluOpBus]   aluop_q;
  logic [`AluSelBus]  alusel_q;
  logic [DATA_W-1:0]  reg1_q, reg2_q;
  logic [4:0]         wd_q;
  logic               wreg_q;
  logic [SHAMT_W-1:0] shamt;
  logic               shift_op;
  logic [DATA_W-1:0]  logic_res, arith_res, shift_res;

  always_ff @(posedge clk) begin
    if (rst == `RstEnable || (id_stall_i && !ex_stall_i)) begin
      aluop_q  <= `EXE_NOP_OP;
      alusel_q <= `EXE_RES_NOP;
      reg1_q   <= '0;
      reg2_q   <= '0;
      wd_q     <= '0;
      wreg_q   <= 1'b0;
    end else if (!ex_stall_i) begin
      aluop_q  <= id.aluop;
      alusel_q <= id.alusel;
      reg1_q   <= id.reg1;
      reg2_q   <= id.reg2;
      wd_q     <= id.wd;
      wreg_q   <= id.wreg;
    end
  end

  assign shamt    = reg2_q[SHAMT_W-1:0];
  assign shift_op = (alusel_q == `EXE_RES_SHIFT) &&
                    (aluop_q == `EXE_SLL_OP || aluop_q == `EXE_SRL_OP ||
                     aluop_q == `EXE_SRA_OP);

  always_comb begin
    logic_res = '0;
    case (aluop_q)
      `EXE_AND_OP: logic_res = reg1_q & reg2_q;
      `EXE_OR_OP:  logic_res = reg1_q | reg2_q;
      `EXE_XOR_OP: logic_res = reg1_q ^ reg2_q;
      default:     logic_res = '0;
    endcase
  end

  always_comb begin
    arith_res = '0;
    case (aluop_q)
      `EXE_ADD_OP:  arith_res = reg1_q + reg2_q;
      `EXE_SUB_OP:  arith_res = reg1_q - reg2_q;
      `EXE_SLT_OP:  arith_res = DATA_W'($signed(reg1_q) < $signed(reg2_q));
      `EXE_SLTU_OP: arith_res = DATA_W'(reg1_q < reg2_q);
      default:      arith_res = '0;
    endcase
  end

`ifdef SERIAL_SHIFT_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t             state, state_nxt;
  logic [DATA_W-1:0]  acc;
  logic [SHAMT_W-1:0] cnt;
  logic               start;
  logic               pending;

  // The serial op is launched on the same edge that latches it, so the stall
  // request is already up in the first cycle the op sits in the latch. DONE
  // may launch the next shift directly so back-to-back shifts do not stall twice.
  assign start = (rst != `RstEnable) && !ex_stall_i && !id_stall_i &&
                 (id.alusel == `EXE_RES_SHIFT) &&
                 (id.aluop == `EXE_SLL_OP || id.aluop == `EXE_SRL_OP ||
                  id.aluop == `EXE_SRA_OP) &&
                 (id.reg2[SHAMT_W-1:0] != '0);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_BUSY;
      S_BUSY:  if (cnt == SHAMT_W'(1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_BUSY : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == `RstEnable) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state != S_BUSY && start) begin
        acc <= id.reg1;
        cnt <= id.reg2[SHAMT_W-1:0];
      end else if (state == S_BUSY) begin
        cnt <= cnt - SHAMT_W'(1);
        case (aluop_q)
          `EXE_SLL_OP: acc <= {acc[DATA_W-2:0], 1'b0};
          `EXE_SRA_OP: acc <= {acc[DATA_W-1], acc[DATA_W-1:1]};
          default:     acc <= {1'b0, acc[DATA_W-1:1]};
        endcase
      end
    end
  end

  assign pending    = shift_op && (shamt != '0) && (state != S_DONE);
  assign stallreq_o = (state == S_BUSY);

  always_comb begin
    shift_res = '0;
    if (shift_op) begin
      if (state == S_DONE)    shift_res = acc;
      else if (shamt == '0)   shift_res = reg1_q;
    end
  end
`else
  logic pending;
  assign pending    = 1'b0;
  assign stallreq_o = 1'b0;

  always_comb begin
    shift_res = '0;
    case (aluop_q)
      `EXE_SLL_OP: shift_res = reg1_q << shamt;
      `EXE_SRL_OP: shift_res = reg1_q >> shamt;
      `EXE_SRA_OP: shift_res = DATA_W'($signed(reg1_q) >>> shamt);
      default:     shift_res = '0;
    endcase
  end
`endif

  always_comb begin
    wdata_o = '0;
    case (alusel_q)
      `EXE_RES_LOGIC:      wdata_o = logic_res;
      `EXE_RES_SHIFT:      wdata_o = shift_res;
      `EXE_RES_ARITHMETIC: wdata_o = arith_res;
      default:             wdata_o = '0;
    endcase
  end

  assign wd_o   = wd_q;
  assign wreg_o = wreg_q && !pending;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: reset, ALU ops, result selection, bubble and
// hold behaviour, and (with SERIAL_SHIFT_EN) the serial shifter handshake.
`ifndef EX_STAGE_DEFS
`define EX_STAGE_DEFS
`define RstEnable          1'b0
`define AluOpBus           7:0
`define AluSelBus          2:0
`define EXE_NOP_OP         8'b0000_0000
`define EXE_AND_OP         8'b0010_0100
`define EXE_OR_OP          8'b0010_0101
`define EXE_XOR_OP         8'b0010_0110
`define EXE_SLL_OP         8'b0111_1100
`define EXE_SRL_OP         8'b0000_0010
`define EXE_SRA_OP         8'b0000_0011
`define EXE_ADD_OP         8'b0010_0000
`define EXE_SUB_OP         8'b0010_0010
`define EXE_SLT_OP         8'b0010_1010
`define EXE_SLTU_OP        8'b0010_1011
`define EXE_RES_NOP        3'b000
`define EXE_RES_LOGIC      3'b001
`define EXE_RES_SHIFT      3'b010
`define EXE_RES_ARITHMETIC 3'b100
`endif

module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_stall;
  logic        ex_stall_drv;
  logic        ex_stall;
  logic [31:0] wdata;
  logic [4:0]  wd;
  logic        wreg;
  logic        stallreq;
  int          checks = 0;
  int          errors = 0;

  ex_stage_if #(.DATA_W(32)) bus ();

  ex_stage #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .id         (bus.slave),
    .id_stall_i (id_stall),
    .ex_stall_i (ex_stall),
    .wdata_o    (wdata),
    .wd_o       (wd),
    .wreg_o     (wreg),
    .stallreq_o (stallreq)
  );

  always #5 clk = ~clk;

  // Controller model: hold this stage whenever it asks for it.
  assign ex_stall = ex_stall_drv | stallreq;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [4:0] d, input logic we);
    bus.aluop  = op;
    bus.alusel = sel;
    bus.reg1   = r1;
    bus.reg2   = r2;
    bus.wd     = d;
    bus.wreg   = we;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; id_stall = 1'b0; ex_stall_drv = 1'b0;
    drive(`EXE_ADD_OP, `EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
    step();
    step();
    chk("rst_wreg", {31'b0, wreg}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_wd", {27'b0, wd}, 32'd0);
    chk("rst_stallreq", {31'b0, stallreq}, 32'd0);
    rst = 1'b1;
    step();
    chk("add_wrap", wdata, 32'd0);
    chk("add_wd", {27'b0, wd}, 32'd5);
    chk("add_wreg", {31'b0, wreg}, 32'd1);

    drive(`EXE_SUB_OP, `EXE_RES_ARITHMETIC, 32'd3, 32'd5, 5'd6, 1'b1);
    step();
    chk("sub", wdata, 32'hFFFF_FFFE);
    chk("sub_wd", {27'b0, wd}, 32'd6);
    drive(`EXE_SLT_OP, `EXE_RES_ARITHMETIC, 32'h8000_0000, 32'd1, 5'd1, 1'b1);
    step();
    chk("slt", wdata, 32'd1);
    drive(`EXE_SLTU_OP, `EXE_RES_ARITHMETIC, 32'h8000_0000, 32'd1, 5'd1, 1'b1);
    step();
    chk("sltu", wdata, 32'd0);

`ifndef SERIAL_SHIFT_EN
    drive(`EXE_SRA_OP, `EXE_RES_SHIFT, 32'h8000_0000, 32'd31, 5'd2, 1'b1);
    step();
    chk("sra31", wdata, 32'hFFFF_FFFF);
    drive(`EXE_SRL_OP, `EXE_RES_SHIFT, 32'h8000_0000, 32'd31, 5'd2, 1'b1);
    step();
    chk("srl31", wdata, 32'd1);
    drive(`EXE_SLL_OP, `EXE_RES_SHIFT, 32'h0000_0003, 32'd4, 5'd2, 1'b1);
    step();
    chk("sll4", wdata, 32'h30);
`endif
    drive(`EXE_SLL_OP, `EXE_RES_SHIFT, 32'd1, 32'd0, 5'd2, 1'b1);
    step();
    chk("sll0", wdata, 32'd1);
    chk("sll0_wreg", {31'b0, wreg}, 32'd1);

    drive(`EXE_AND_OP, `EXE_RES_LOGIC, 32'h0000_F0F0, 32'h0000_FF00, 5'd3, 1'b1);
    step();
    chk("and", wdata, 32'h0000_F000);
    drive(`EXE_XOR_OP, `EXE_RES_LOGIC, 32'h0000_F0F0, 32'h0000_FF00, 5'd3, 1'b1);
    step();
    chk("xor", wdata, 32'h0000_0FF0);
    drive(`EXE_ADD_OP, 3'b111, 32'd7, 32'd8, 5'd4, 1'b1);
    step();
    chk("bad_sel", wdata, 32'd0);
    drive(8'hEE, `EXE_RES_ARITHMETIC, 32'd7, 32'd8, 5'd4, 1'b1);
    step();
    chk("bad_op", wdata, 32'd0);
    chk("bad_op_wreg", {31'b0, wreg}, 32'd1);

    drive(`EXE_ADD_OP, `EXE_RES_ARITHMETIC, 32'd2, 32'd3, 5'd7, 1'b1);
    step();
    chk("add5", wdata, 32'd5);
    id_stall = 1'b1;
    drive(`EXE_SUB_OP, `EXE_RES_ARITHMETIC, 32'd9, 32'd1, 5'd8, 1'b1);
    step();
    chk("bubble_wreg", {31'b0, wreg}, 32'd0);
    chk("bubble_wdata", wdata, 32'd0);
    id_stall = 1'b0;
    drive(`EXE_OR_OP, `EXE_RES_LOGIC, 32'h0F, 32'hF0, 5'd9, 1'b1);
    step();
    chk("or", wdata, 32'hFF);
    ex_stall_drv = 1'b1;
    drive(`EXE_ADD_OP, `EXE_RES_ARITHMETIC, 32'd1, 32'd1, 5'd10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      id_stall = (i == 1);
      step();
      chk("hold_wdata", wdata, 32'hFF);
      chk("hold_wd", {27'b0, wd}, 32'd9);
      chk("hold_wreg", {31'b0, wreg}, 32'd1);
    end
    ex_stall_drv = 1'b0; id_stall = 1'b0;
    step();
    chk("after_hold", wdata, 32'd2);
    chk("after_hold_wd", {27'b0, wd}, 32'd10);

`ifdef SERIAL_SHIFT_EN
    drive(`EXE_SLL_OP, `EXE_RES_SHIFT, 32'd1, 32'd4, 5'd3, 1'b1);
    step();
    drive(`EXE_ADD_OP, `EXE_RES_ARITHMETIC, 32'd1, 32'd1, 5'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("ser_stallreq", {31'b0, stallreq}, 32'd1);
      chk("ser_wreg", {31'b0, wreg}, 32'd0);
      chk("ser_wdata", wdata, 32'd0);
      step();
    end
    chk("ser_done_wdata", wdata, 32'h10);
    chk("ser_done_wreg", {31'b0, wreg}, 32'd1);
    chk("ser_done_stall", {31'b0, stallreq}, 32'd0);
    chk("ser_done_wd", {27'b0, wd}, 32'd3);
    step();
    chk("ser_next", wdata, 32'd2);
    chk("ser_next_wd", {27'b0, wd}, 32'd4);

    drive(`EXE_SRA_OP, `EXE_RES_SHIFT, 32'h8000_0000, 32'd2, 5'd6, 1'b1);
    step();
    drive(`EXE_NOP_OP, `EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    for (int i = 0; i < 40 && stallreq; i++) step();
    chk("sra_timeout", {31'b0, stallreq}, 32'd0);
    chk("sra_serial", wdata, 32'hE000_0000);
    chk("sra_serial_wreg", {31'b0, wreg}, 32'd1);

    drive(`EXE_SRA_OP, `EXE_RES_SHIFT, 32'hF000_0000, 32'd8, 5'd6, 1'b1);
    step();
    step();
    chk("mid_busy", {31'b0, stallreq}, 32'd1);
    step();
    rst = 1'b0;
    step();
    chk("mid_rst_stall", {31'b0, stallreq}, 32'd0);
    chk("mid_rst_wreg", {31'b0, wreg}, 32'd0);
    chk("mid_rst_wdata", wdata, 32'd0);
    rst = 1'b1;
    drive(`EXE_ADD_OP, `EXE_RES_ARITHMETIC, 32'd4, 32'd4, 5'd1, 1'b1);
    step();
    chk("post_rst_add", wdata, 32'd8);
    chk("post_rst_stall", {31'b0, stallreq}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
